hazard_scoreboard: RTL and testbench

//  Generalised operand-hazard unit for the decode/issue stage. Resolves RAW hazards

---
 rtl/hazard_scoreboard_if.sv | 41 ++++
 rtl/hazard_scoreboard.sv | 85 ++++++++
 tb/tb_hazard_scoreboard.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// Decode/issue hazard bus: ID operands, in-flight stage info, var-latency completion
// in; forwarding selects, stall, issue and stall counter out.
interface hazard_scoreboard_if #(
   parameter int NUM_STAGES = 2,
   parameter int CNT_W      = 32
);
   localparam int SEL_W = $clog2(NUM_STAGES + 1);

   logic                    flush_i;
   logic                    id_valid_i;
   logic [4:0]              rs1_addr_i;
   logic [4:0]              rs2_addr_i;
   logic                    rs1_used_i;
   logic                    rs2_used_i;
   logic [4:0]              id_rd_i;
   logic                    id_is_vl_i;
   logic [5*NUM_STAGES-1:0] stage_rd_i;
   logic [NUM_STAGES-1:0]   stage_reg_write_i;
   logic [NUM_STAGES-1:0]   stage_is_load_i;
   logic                    vl_done_i;
   logic [4:0]              vl_done_rd_i;
   logic [SEL_W-1:0]        forward_a_o;
   logic [SEL_W-1:0]        forward_b_o;
   logic                    stall_o;
   logic                    vl_issue_o;
   logic [CNT_W-1:0]        stall_cnt_o;

   modport master (
      output flush_i, id_valid_i, rs1_addr_i, rs2_addr_i, rs1_used_i, rs2_used_i,
             id_rd_i, id_is_vl_i, stage_rd_i, stage_reg_write_i, stage_is_load_i,
             vl_done_i, vl_done_rd_i,
      input  forward_a_o, forward_b_o, stall_o, vl_issue_o, stall_cnt_o
   );

   modport slave (
      input  flush_i, id_valid_i, rs1_addr_i, rs2_addr_i, rs1_used_i, rs2_used_i,
             id_rd_i, id_is_vl_i, stage_rd_i, stage_reg_write_i, stage_is_load_i,
             vl_done_i, vl_done_rd_i,
      output forward_a_o, forward_b_o, stall_o, vl_issue_o, stall_cnt_o
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// Operand hazard unit: priority forwarding across in-flight stages, load-use detection
// and a busy scoreboard for the variable-latency unit.
module hazard_scoreboard #(
   parameter int NUM_STAGES = 2,
   parameter int MAX_OUTST  = 4,
   parameter int CNT_W      = 32
) (
   input  logic               clk_i,
   input  logic               rst_i,
   hazard_scoreboard_if.slave bus
);
   localparam int SEL_W   = $clog2(NUM_STAGES + 1);
   localparam int OUTST_W = $clog2(MAX_OUTST + 1);

   logic [31:1]        r_busy;
   logic [OUTST_W-1:0] r_outst;
   logic [CNT_W-1:0]   r_stall_cnt;

   logic [SEL_W-1:0]   w_sel_a, w_sel_b;
   logic               w_ld_a, w_ld_b;
   logic               w_done, w_need_ld, w_sb_haz, w_full, w_stall, w_issue;
   logic [31:0]        w_busy, w_busy_nxt;

   // Returns {load-in-EX, select}; scanning oldest to youngest lets the youngest win.
   function automatic logic [SEL_W:0] fwd_sel(input logic [4:0] rs,
                                              input logic [5*NUM_STAGES-1:0] rd,
                                              input logic [NUM_STAGES-1:0] wr,
                                              input logic [NUM_STAGES-1:0] ld);
      logic [SEL_W:0] res;
      res = '0;
      for (int k = NUM_STAGES - 1; k >= 0; k--) begin
         if (wr[k] && rd[5*k +: 5] != 5'd0 && rd[5*k +: 5] == rs)
            res = {ld[k] && (k == 0), SEL_W'(k + 1)};
      end
      return res;
   endfunction

   always_comb begin
      {w_ld_a, w_sel_a} = fwd_sel(bus.rs1_addr_i, bus.stage_rd_i,
                                  bus.stage_reg_write_i, bus.stage_is_load_i);
      {w_ld_b, w_sel_b} = fwd_sel(bus.rs2_addr_i, bus.stage_rd_i,
                                  bus.stage_reg_write_i, bus.stage_is_load_i);
   end

   // A completion with nothing outstanding is ignored entirely, bypass included.
   assign w_done = bus.vl_done_i && (r_outst != '0);
   assign w_busy = {r_busy, 1'b0} & ~(w_done ? (32'd1 << bus.vl_done_rd_i) : 32'd0);

   assign w_need_ld = (bus.rs1_used_i && w_ld_a) || (bus.rs2_used_i && w_ld_b);
   assign w_sb_haz  = (bus.rs1_used_i && w_busy[bus.rs1_addr_i]) ||
                      (bus.rs2_used_i && w_busy[bus.rs2_addr_i]) ||
                      w_busy[bus.id_rd_i];
   assign w_full    = bus.id_is_vl_i && (r_outst == OUTST_W'(MAX_OUTST)) && !bus.vl_done_i;

   assign w_stall = !rst_i && bus.id_valid_i && !bus.flush_i &&
                    (w_need_ld || w_sb_haz || w_full);
   assign w_issue = !rst_i && bus.id_valid_i && bus.id_is_vl_i && !w_stall && !bus.flush_i;

   // Set after clear so a same-register done+issue leaves the register busy.
   assign w_busy_nxt = w_busy | (w_issue ? (32'd1 << bus.id_rd_i) : 32'd0);

   assign bus.forward_a_o = rst_i ? '0 : w_sel_a;
   assign bus.forward_b_o = rst_i ? '0 : w_sel_b;
   assign bus.stall_o     = w_stall;
   assign bus.vl_issue_o  = w_issue;
   assign bus.stall_cnt_o = r_stall_cnt;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_busy      <= '0;
         r_outst     <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (w_stall && r_stall_cnt != '1)
            r_stall_cnt <= r_stall_cnt + 1'b1;
         if (bus.flush_i) begin
            r_busy  <= '0;
            r_outst <= '0;
         end else begin
            r_busy  <= w_busy_nxt[31:1];
            r_outst <= r_outst + OUTST_W'(w_issue) - OUTST_W'(w_done);
         end
      end
   end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed scenarios plus randomized traffic against a rule-level reference model.
module tb_hazard_scoreboard;
   localparam int NS  = 2;
   localparam int MAX = 4;
   localparam int CW  = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_pass = 0;

   bit            m_busy [32];
   int            m_outst;
   logic [CW-1:0] m_cnt;

   hazard_scoreboard_if #(.NUM_STAGES(NS), .CNT_W(CW)) bus ();

   hazard_scoreboard #(.NUM_STAGES(NS), .MAX_OUTST(MAX), .CNT_W(CW)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic int m_sel(input logic [4:0] rs);
      if (rst || rs == 5'd0) return 0;
      for (int k = 0; k < NS; k++)
         if (bus.stage_reg_write_i[k] && bus.stage_rd_i[5*k +: 5] == rs) return k + 1;
      return 0;
   endfunction

   function automatic bit m_bz(input logic [4:0] rs);
      bit dn;
      dn = bus.vl_done_i && m_outst > 0 && bus.vl_done_rd_i == rs;
      return rs != 5'd0 && m_busy[rs] && !dn;
   endfunction

   function automatic bit m_stall();
      bit ld, sb, full;
      if (rst || !bus.id_valid_i || bus.flush_i) return 0;
      ld   = (bus.rs1_used_i && m_sel(bus.rs1_addr_i) == 1 && bus.stage_is_load_i[0]) ||
             (bus.rs2_used_i && m_sel(bus.rs2_addr_i) == 1 && bus.stage_is_load_i[0]);
      sb   = (bus.rs1_used_i && m_bz(bus.rs1_addr_i)) ||
             (bus.rs2_used_i && m_bz(bus.rs2_addr_i)) || m_bz(bus.id_rd_i);
      full = bus.id_is_vl_i && m_outst == MAX && !bus.vl_done_i;
      return ld || sb || full;
   endfunction

   function automatic bit m_issue();
      return !rst && bus.id_valid_i && bus.id_is_vl_i && !bus.flush_i && !m_stall();
   endfunction

   task automatic tick();
      bit s, iss, dn;
      logic [4:0] drd, ird;
      s = m_stall(); iss = m_issue();
      dn = bus.vl_done_i && m_outst > 0;
      drd = bus.vl_done_rd_i; ird = bus.id_rd_i;
      @(posedge clk);
      if (rst) begin
         foreach (m_busy[i]) m_busy[i] = 0;
         m_outst = 0; m_cnt = '0;
      end else begin
         if (s && m_cnt != '1) m_cnt = m_cnt + 1;
         if (bus.flush_i) begin
            foreach (m_busy[i]) m_busy[i] = 0;
            m_outst = 0;
         end else begin
            if (dn) begin m_busy[drd] = 0; m_outst--; end
            if (iss) begin
               if (ird != 5'd0) m_busy[ird] = 1;
               m_outst++;
            end
         end
      end
      #1;
   endtask

   task automatic set_idle();
      bus.flush_i = 0; bus.id_valid_i = 0; bus.rs1_addr_i = 0; bus.rs2_addr_i = 0;
      bus.rs1_used_i = 0; bus.rs2_used_i = 0; bus.id_rd_i = 0; bus.id_is_vl_i = 0;
      bus.stage_rd_i = '0; bus.stage_reg_write_i = '0; bus.stage_is_load_i = '0;
      bus.vl_done_i = 0; bus.vl_done_rd_i = 0;
   endtask

   task automatic vl_op(input logic [4:0] rd);
      bus.id_valid_i = 1; bus.id_is_vl_i = 1; bus.id_rd_i = rd;
      bus.rs1_used_i = 0; bus.rs2_used_i = 0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      set_idle(); rst = 1;
      tick(); tick();
      rst = 0; #1;
      n_chk++; if (bus.stall_cnt_o !== 0) $display("FAIL rst_cnt: got %0d want 0", bus.stall_cnt_o); else n_pass++;
      n_chk++; if (bus.stall_o !== 0 || bus.vl_issue_o !== 0) $display("FAIL rst_outs: stall %b issue %b want 0 0", bus.stall_o, bus.vl_issue_o); else n_pass++;
      n_chk++; if (bus.forward_a_o !== 0 || bus.forward_b_o !== 0) $display("FAIL rst_fwd: a %0d b %0d want 0 0", bus.forward_a_o, bus.forward_b_o); else n_pass++;
   endtask

   task automatic test_forwarding();
      set_idle();
      bus.stage_rd_i = {5'd5, 5'd5}; bus.stage_reg_write_i = 2'b11;
      bus.rs1_addr_i = 5; bus.rs2_addr_i = 5; #1;
      n_chk++; if (bus.forward_a_o !== 1) $display("FAIL fwd_ex_wins: got %0d want 1", bus.forward_a_o); else n_pass++;
      n_chk++; if (bus.forward_b_o !== 1) $display("FAIL fwd_b_ex: got %0d want 1", bus.forward_b_o); else n_pass++;
      bus.stage_rd_i = {5'd5, 5'd0}; #1;
      n_chk++; if (bus.forward_a_o !== 2) $display("FAIL fwd_ex_x0_mem: got %0d want 2", bus.forward_a_o); else n_pass++;
      bus.stage_reg_write_i = 2'b01; #1;
      n_chk++; if (bus.forward_a_o !== 0) $display("FAIL fwd_mem_nowrite: got %0d want 0", bus.forward_a_o); else n_pass++;
      bus.stage_rd_i = {5'd0, 5'd0}; bus.stage_reg_write_i = 2'b11; bus.rs1_addr_i = 0; #1;
      n_chk++; if (bus.forward_a_o !== 0) $display("FAIL fwd_x0: got %0d want 0", bus.forward_a_o); else n_pass++;
   endtask

   task automatic test_load_use();
      set_idle();
      bus.id_valid_i = 1; bus.rs2_addr_i = 7; bus.rs2_used_i = 1;
      bus.stage_rd_i = {5'd0, 5'd7}; bus.stage_reg_write_i = 2'b01; bus.stage_is_load_i = 2'b01; #1;
      n_chk++; if (bus.stall_o !== 1) $display("FAIL ld_use_ex: got %b want 1", bus.stall_o); else n_pass++;
      tick();
      bus.stage_rd_i = {5'd7, 5'd0}; bus.stage_reg_write_i = 2'b10; bus.stage_is_load_i = 2'b10; #1;
      n_chk++; if (bus.stall_o !== 0 || bus.forward_b_o !== 2) $display("FAIL ld_mem_fwd: stall %b fwd %0d want 0 2", bus.stall_o, bus.forward_b_o); else n_pass++;
      tick();
      n_chk++; if (bus.stall_cnt_o !== 1) $display("FAIL ld_cnt: got %0d want 1", bus.stall_cnt_o); else n_pass++;
      bus.stage_rd_i = {5'd0, 5'd7}; bus.stage_reg_write_i = 2'b01; bus.stage_is_load_i = 2'b01;
      bus.rs2_used_i = 0; #1;
      n_chk++; if (bus.stall_o !== 0 || bus.forward_b_o !== 1) $display("FAIL ld_unused: stall %b fwd %0d want 0 1", bus.stall_o, bus.forward_b_o); else n_pass++;
      tick();
   endtask

   task automatic test_vl_stall();
      logic [CW-1:0] c0;
      set_idle(); vl_op(9); #1;
      n_chk++; if (bus.vl_issue_o !== 1) $display("FAIL div_issue: got %b want 1", bus.vl_issue_o); else n_pass++;
      tick();
      bus.id_is_vl_i = 0; bus.id_rd_i = 10; bus.rs1_addr_i = 9; bus.rs1_used_i = 1;
      c0 = m_cnt;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_chk++; if (bus.stall_o !== 1) $display("FAIL div_dep_stall%0d: got %b want 1", i, bus.stall_o); else n_pass++;
         tick();
      end
      bus.vl_done_i = 1; bus.vl_done_rd_i = 9; #1;
      n_chk++; if (bus.stall_o !== 0) $display("FAIL div_done_bypass: got %b want 0", bus.stall_o); else n_pass++;
      tick();
      set_idle(); #1;
      n_chk++; if (bus.stall_cnt_o !== c0 + 3) $display("FAIL div_cnt: got %0d want %0d", bus.stall_cnt_o, c0 + 3); else n_pass++;
   endtask

   task automatic test_full();
      set_idle();
      for (int i = 1; i <= 4; i++) begin
         vl_op(5'(i)); #1;
         n_chk++; if (bus.vl_issue_o !== 1) $display("FAIL full_issue%0d: got %b want 1", i, bus.vl_issue_o); else n_pass++;
         tick();
      end
      vl_op(5); #1;
      n_chk++; if (bus.stall_o !== 1 || bus.vl_issue_o !== 0) $display("FAIL full_5th: stall %b issue %b want 1 0", bus.stall_o, bus.vl_issue_o); else n_pass++;
      tick();
      bus.vl_done_i = 1; bus.vl_done_rd_i = 1; #1;
      n_chk++; if (bus.stall_o !== 0 || bus.vl_issue_o !== 1) $display("FAIL full_done_accept: stall %b issue %b want 0 1", bus.stall_o, bus.vl_issue_o); else n_pass++;
      tick();
      bus.vl_done_i = 0; vl_op(6); #1;
      n_chk++; if (bus.stall_o !== 1) $display("FAIL full_still4: got %b want 1", bus.stall_o); else n_pass++;
      bus.id_is_vl_i = 0; bus.id_rd_i = 0; bus.rs1_used_i = 1; bus.rs1_addr_i = 1; #1;
      n_chk++; if (bus.stall_o !== 0) $display("FAIL full_x1_free: got %b want 0", bus.stall_o); else n_pass++;
      bus.rs1_addr_i = 5; #1;
      n_chk++; if (bus.stall_o !== 1) $display("FAIL full_x5_busy: got %b want 1", bus.stall_o); else n_pass++;
      tick();
   endtask

   task automatic test_done_issue_flush();
      logic [CW-1:0] c0;
      set_idle(); bus.flush_i = 1; tick(); bus.flush_i = 0;
      vl_op(3); tick(); vl_op(7); tick(); vl_op(8); tick();
      vl_op(3); bus.vl_done_i = 1; bus.vl_done_rd_i = 3; #1;
      n_chk++; if (bus.vl_issue_o !== 1 || bus.stall_o !== 0) $display("FAIL same_reg_issue: issue %b stall %b want 1 0", bus.vl_issue_o, bus.stall_o); else n_pass++;
      tick();
      set_idle(); bus.id_valid_i = 1; bus.rs1_used_i = 1; bus.rs1_addr_i = 3; #1;
      n_chk++; if (bus.stall_o !== 1) $display("FAIL same_reg_set_wins: got %b want 1", bus.stall_o); else n_pass++;
      tick();
      bus.flush_i = 1; #1;
      n_chk++; if (bus.stall_o !== 0) $display("FAIL flush_no_stall: got %b want 0", bus.stall_o); else n_pass++;
      c0 = m_cnt;
      tick(); bus.flush_i = 0;
      bus.rs2_used_i = 1; bus.rs2_addr_i = 7; #1;
      n_chk++; if (bus.stall_cnt_o !== c0 || c0 == 0) $display("FAIL flush_cnt_held: got %0d want %0d nonzero", bus.stall_cnt_o, c0); else n_pass++;
      n_chk++; if (bus.stall_o !== 0) $display("FAIL flush_busy_clr: got %b want 0", bus.stall_o); else n_pass++;
      for (int i = 10; i < 14; i++) begin vl_op(5'(i)); tick(); end
      vl_op(14); #1;
      n_chk++; if (bus.stall_o !== 1) $display("FAIL flush_outst0: got %b want 1", bus.stall_o); else n_pass++;
      set_idle(); bus.flush_i = 1; tick(); bus.flush_i = 0;
   endtask

   task automatic test_reset_mid();
      set_idle(); vl_op(9); tick();
      bus.id_is_vl_i = 0; bus.id_rd_i = 0; bus.rs1_used_i = 1; bus.rs1_addr_i = 9; #1;
      n_chk++; if (bus.stall_o !== 1) $display("FAIL mid_pre_stall: got %b want 1", bus.stall_o); else n_pass++;
      tick();
      rst = 1; bus.stage_rd_i = {5'd9, 5'd9}; bus.stage_reg_write_i = 2'b11; bus.rs2_addr_i = 9; #1;
      n_chk++; if (bus.stall_o !== 0 || bus.vl_issue_o !== 0) $display("FAIL mid_rst_outs: stall %b issue %b want 0 0", bus.stall_o, bus.vl_issue_o); else n_pass++;
      n_chk++; if (bus.forward_a_o !== 0 || bus.forward_b_o !== 0) $display("FAIL mid_rst_fwd: a %0d b %0d want 0 0", bus.forward_a_o, bus.forward_b_o); else n_pass++;
      tick(); rst = 0; #1;
      n_chk++; if (bus.stall_cnt_o !== 0 || bus.stall_o !== 0) $display("FAIL mid_rst_clr: cnt %0d stall %b want 0 0", bus.stall_cnt_o, bus.stall_o); else n_pass++;
      n_chk++; if (bus.forward_a_o !== 1) $display("FAIL mid_post_fwd: got %0d want 1", bus.forward_a_o); else n_pass++;
      tick();
   endtask

   task automatic test_random();
      int es, ei, ea, eb;
      for (int c = 0; c < 400; c++) begin
         rst = ($urandom_range(63) == 0);
         bus.flush_i = ($urandom_range(15) == 0);
         bus.id_valid_i = $urandom_range(3) != 0;
         bus.rs1_addr_i = 5'($urandom_range(7)); bus.rs2_addr_i = 5'($urandom_range(7));
         bus.rs1_used_i = 1'($urandom); bus.rs2_used_i = 1'($urandom);
         bus.id_rd_i = 5'($urandom_range(7)); bus.id_is_vl_i = 1'($urandom);
         bus.stage_rd_i = {5'($urandom_range(7)), 5'($urandom_range(7))};
         bus.stage_reg_write_i = 2'($urandom); bus.stage_is_load_i = 2'($urandom);
         bus.vl_done_i = ($urandom_range(2) == 0); bus.vl_done_rd_i = 5'($urandom_range(7));
         #1;
         es = m_stall(); ei = m_issue();
         ea = m_sel(bus.rs1_addr_i); eb = m_sel(bus.rs2_addr_i);
         n_chk++; if (bus.stall_o !== 1'(es)) $display("FAIL rnd_stall c%0d: got %b want %0d", c, bus.stall_o, es); else n_pass++;
         n_chk++; if (bus.vl_issue_o !== 1'(ei)) $display("FAIL rnd_issue c%0d: got %b want %0d", c, bus.vl_issue_o, ei); else n_pass++;
         n_chk++; if (bus.forward_a_o !== 2'(ea)) $display("FAIL rnd_fwd_a c%0d: got %0d want %0d", c, bus.forward_a_o, ea); else n_pass++;
         n_chk++; if (bus.forward_b_o !== 2'(eb)) $display("FAIL rnd_fwd_b c%0d: got %0d want %0d", c, bus.forward_b_o, eb); else n_pass++;
         n_chk++; if (bus.stall_cnt_o !== m_cnt) $display("FAIL rnd_cnt c%0d: got %0d want %0d", c, bus.stall_cnt_o, m_cnt); else n_pass++;
         tick();
      end
      rst = 0; set_idle();
   endtask

   initial begin
      foreach (m_busy[i]) m_busy[i] = 0;
      m_outst = 0; m_cnt = '0;
      test_reset();
      test_forwarding();
      test_load_use();
      test_vl_stall();
      test_full();
      test_done_issue_flush();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
